// File: rtl/rob_recovery_ctrl.sv
// Branch-mispredict recovery sequencer for the ROB: picks the oldest report, pulses rollback/redirect, stalls dispatch until the branch retires.
// Optional performance counters are compiled in when ROB_RECOVERY_PERF_EN is defined.
module rob_recovery_ctrl #(
    parameter  int NUM_SUPER = 2,
    parameter  int NUM_ROB   = 32,
    localparam int IDX_W     = $clog2(NUM_ROB)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                en,
    input  logic [NUM_SUPER-1:0]                mispred_valid,
    input  logic [NUM_SUPER-1:0][IDX_W-1:0]     mispred_rob_idx,
    input  logic [NUM_SUPER-1:0][63:0]          mispred_target,
    input  logic [IDX_W-1:0]                    rob_head,
    input  logic [NUM_SUPER-1:0]                rob_retire_en,
    output logic                                rollback_en,
    output logic [IDX_W-1:0]                    rollback_idx,
    output logic                                redirect_valid,
    output logic [63:0]                         redirect_pc,
    output logic                                dispatch_stall,
    output logic                                busy
`ifdef ROB_RECOVERY_PERF_EN
    ,
    output logic [31:0]                         perf_mispred_cnt,
    output logic [31:0]                         perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROLLBACK,
        ST_DRAIN
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_pend_idx;
    logic [IDX_W-1:0]  r_rollback_idx;
    logic [63:0]       r_redirect_pc;
    logic              r_pulse_seen;

    logic              w_sel_valid;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [63:0]       w_sel_target;
    logic [IDX_W-1:0]  w_sel_age;
    logic [IDX_W-1:0]  w_lane_age;
    logic [IDX_W-1:0]  w_pend_age;
    logic              w_older;
    logic              w_retire_hit;
    logic              w_pulse;

    // Strict less-than keeps the lowest lane on equal age.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_idx    = '0;
        w_sel_target = '0;
        w_sel_age    = '0;
        w_lane_age   = '0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            w_lane_age = mispred_rob_idx[i] - rob_head;
            if (mispred_valid[i] && (!w_sel_valid || (w_lane_age < w_sel_age))) begin
                w_sel_valid  = 1'b1;
                w_sel_idx    = mispred_rob_idx[i];
                w_sel_target = mispred_target[i];
                w_sel_age    = w_lane_age;
            end
        end
    end

    always_comb begin
        w_retire_hit = 1'b0;
        for (int j = 0; j < NUM_SUPER; j++) begin
            if (rob_retire_en[j] && ((rob_head + IDX_W'(j)) == r_pend_idx)) begin
                w_retire_hit = 1'b1;
            end
        end
    end

    assign w_pend_age = r_pend_idx - rob_head;
    assign w_older    = w_sel_valid && (w_sel_age < w_pend_age);

    // A ROLLBACK state that sits through en==0 cycles shows its pulse only on the first clock.
    assign w_pulse = (r_state == ST_ROLLBACK) && !r_pulse_seen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_pend_idx     <= '0;
            r_rollback_idx <= '0;
            r_redirect_pc  <= '0;
            r_pulse_seen   <= 1'b0;
        end else if (en) begin
            r_pulse_seen <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_state        <= ST_ROLLBACK;
                        r_pend_idx     <= w_sel_idx;
                        r_rollback_idx <= w_sel_idx + 1'b1;
                        r_redirect_pc  <= w_sel_target;
                    end
                end
                ST_ROLLBACK: begin
                    if (w_older) begin
                        r_pend_idx     <= w_sel_idx;
                        r_rollback_idx <= w_sel_idx + 1'b1;
                        r_redirect_pc  <= w_sel_target;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_older) begin
                        r_state        <= ST_ROLLBACK;
                        r_pend_idx     <= w_sel_idx;
                        r_rollback_idx <= w_sel_idx + 1'b1;
                        r_redirect_pc  <= w_sel_target;
                    end else if (w_retire_hit) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end else if (r_state == ST_ROLLBACK) begin
            r_pulse_seen <= 1'b1;
        end
    end

    assign rollback_en    = w_pulse;
    assign redirect_valid = w_pulse;
    assign rollback_idx   = r_rollback_idx;
    assign redirect_pc    = r_redirect_pc;
    assign dispatch_stall = (r_state != ST_IDLE);
    assign busy           = (r_state != ST_IDLE);

`ifdef ROB_RECOVERY_PERF_EN
    logic [31:0] r_perf_mispred_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_mispred_cnt <= '0;
            r_perf_stall_cnt   <= '0;
        end else begin
            if (w_pulse && (r_perf_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_perf_mispred_cnt <= r_perf_mispred_cnt + 32'd1;
            end
            if (en && dispatch_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_mispred_cnt = r_perf_mispred_cnt;
    assign perf_stall_cnt   = r_perf_stall_cnt;
`endif

endmodule
